inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front-end of the RISC-V core. Generates the PC, issues in-order read requests on the instruction bus, buffers returned words with their PCs in a 2-entry FIFO, and presents them with a valid/ready handshake to the IF/ID pipeline register. Handles redirects from execute (jump/branch) by flushing buffered and in-flight instructions.

## Interface
- ADDR_WIDTH, 32, PC / bus address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- sys_clk_i  input  1  core clock; all logic on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- req_valid_o  output  1  fetch request valid
- req_addr_o  output  ADDR_WIDTH  fetch address (word aligned)
- req_ready_i  input  1  bus accepts request this cycle
- rsp_valid_i  input  1  read data valid (in request order)
- rsp_data_i  input  DATA_WIDTH  read data
- jump_en_i  input  1  redirect request from execute
- jump_addr_i  input  ADDR_WIDTH  redirect target
- inst_valid_o  output  1  instruction available to IF/ID
- inst_ready_i  input  1  IF/ID consumes this cycle
- inst_o  output  DATA_WIDTH  instruction; NOP (32'h0000_0013) when inst_valid_o low
- inst_addr_o  output  ADDR_WIDTH  PC of inst_o; 0 when inst_valid_o low
- misalign_o  output  1  one-cycle pulse, misaligned redirect (macro only; tied 0 otherwise)

## Operation
- FSM: BOOT -> RUN (unconditional, one cycle); RUN -> HALT on misaligned redirect (macro only); HALT -> RUN on aligned redirect. No requests in BOOT/HALT.
- Outstanding counter out_cnt (0..2): +1 on request accept, -1 on rsp_valid_i.
- Credit rule: req_valid_o = (state==RUN) && !jump_en_i && (out_cnt + fifo_cnt < 2). FIFO can never overflow; bench asserts this.
- Accept (req_valid_o && req_ready_i): pc <= pc + 4; record pc into address queue.
- Response: if drop_cnt > 0, discard and decrement drop_cnt; else push {pc_queue_head, rsp_data_i} into FIFO.
- Pop: inst_valid_o && inst_ready_i. inst_o/inst_addr_o stable while valid and not ready.
- Redirect (jump_en_i high in RUN): FIFO flushed, pc <= jump_addr_i, drop_cnt <= out_cnt - rsp_valid_i; a response arriving in the jump cycle is discarded. Redirect in BOOT is ignored.
- Back-to-back redirects: each takes effect; last one wins; drop_cnt recomputed each time.
- Arithmetic: pc wraps modulo 2^ADDR_WIDTH (32'hFFFF_FFFC + 4 -> 0).

## Timing
- Reset values: req_valid_o 0, req_addr_o RESET_PC, inst_valid_o 0, inst_o NOP, inst_addr_o 0, misalign_o 0, out_cnt/drop_cnt/fifo_cnt 0, state BOOT.
- First req_valid_o in second cycle after rst_n_i deasserts.
- rsp_valid_i earliest one cycle after accept; rsp -> inst_valid_o latency 1 cycle (registered FIFO output).
- Redirect -> inst_valid_o low next cycle; first request to target next cycle (subject to credit).
- Simultaneous push and pop on non-empty FIFO: count unchanged, order preserved.
- Reset mid-operation: all state cleared asynchronously; outstanding bus responses after reset release are the bus's responsibility (bus is reset by the same rst_n_i).

## Configuration
- INST_FETCH_MISALIGN_CHK_EN defined: redirect with jump_addr_i[1:0] != 0 pulses misalign_o for one cycle, flushes as a normal redirect, enters HALT.
- Not defined: jump_addr_i[1:0] forced to 0, no HALT state, misalign_o tied 0.

## Structure
- Shared package: INST_NOP (32'h0000_0013), FETCH_DEPTH (2), FSM state encoding, default RESET_PC.
- One sub-module: fetch_fifo, 2-entry synchronous FIFO of {addr, data} with push, pop, flush, count, registered output.

## Test plan
- Reset release, req_ready_i=1, 1-cycle bus -> requests 0x0, 0x4, 0x8; inst_addr_o sequence 0x0, 0x4, 0x8 with correct data.
- inst_ready_i=0 for 10 cycles -> after two responses req_valid_o stays 0; inst_o stable; release -> no loss/duplication.
- Jump to 0x100 with out_cnt=2 -> both stale responses dropped; next inst_addr_o 0x100.
- Jump coinciding with rsp_valid_i and a FIFO pop -> stale word never presented; first valid PC is target.
- PC at 0xFFFF_FFFC -> next request address 0x0000_0000.
- Macro on: jump to 0x102 -> misalign_o one pulse, no requests; jump to 0x200 -> fetch resumes at 0x200.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared constants and FSM encoding
// for the instruction fetch front-end.
package inst_fetch_unit_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          FETCH_DEPTH  = 2;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction bus, redirect and IF/ID
// handshake signals of the fetch front-end.
interface inst_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_o;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic                  req_ready_i;
  logic                  rsp_valid_i;
  logic [DATA_WIDTH-1:0] rsp_data_i;
  logic                  jump_en_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  misalign_o;

  modport master (
    output req_valid_o, req_addr_o,
    output inst_valid_o, inst_o, inst_addr_o,
    output misalign_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i,
    input  jump_en_i, jump_addr_i, inst_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o,
    input  inst_valid_o, inst_o, inst_addr_o,
    input  misalign_o,
    output req_ready_i, rsp_valid_i, rsp_data_i,
    output jump_en_i, jump_addr_i, inst_ready_i
  );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: 2-entry {addr, data} buffer with flush,
// output read straight from the storage registers.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);
  logic [AW-1:0] r_addr [FETCH_DEPTH];
  logic [DW-1:0] r_data [FETCH_DEPTH];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_addr[r_wp] <= i_addr;
        r_data[r_wp] <= i_data;
        r_wp         <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_addr  = r_addr[r_rp];
  assign o_data  = r_data[r_rp];
  assign o_cnt   = r_cnt;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation, in-order bus fetch, 2-deep buffer.
// Define INST_FETCH_MISALIGN_CHK_EN to trap misaligned redirects in HALT.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input logic               sys_clk_i,
  input logic               rst_n_i,
  inst_fetch_unit_if.master bus
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  addr_t                 r_pc;
  addr_t                 w_jaddr;
  addr_t                 r_aq [FETCH_DEPTH];
  logic                  r_aq_wp;
  logic                  r_aq_rp;
  logic [1:0]            r_out_cnt;
  logic [1:0]            r_drop_cnt;
  logic [1:0]            w_fifo_cnt;
  logic                  w_mis;
  logic                  w_redir;
  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_valid;
  addr_t                 w_fifo_addr;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  assign w_redir = bus.jump_en_i && (r_state != ST_BOOT);

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic r_misalign;
  assign w_jaddr = bus.jump_addr_i;
  assign w_mis   = w_redir && (bus.jump_addr_i[1:0] != 2'b00);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_misalign <= 1'b0;
    else          r_misalign <= w_mis;
  end

  assign bus.misalign_o = r_misalign;
`else
  assign w_jaddr        = bus.jump_addr_i & ~addr_t'(3);
  assign w_mis          = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (w_mis) w_state_nxt = ST_HALT;
      ST_HALT: if (w_redir && !w_mis) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Credit covers in-flight words too, so every response has a FIFO slot.
  always_comb begin
    w_req_valid = 1'b0;
    unique case (r_state)
      ST_RUN:
        w_req_valid = !bus.jump_en_i &&
          (({1'b0, r_out_cnt} + {1'b0, w_fifo_cnt})
            < 3'(FETCH_DEPTH));
      default: w_req_valid = 1'b0;
    endcase
  end

  assign w_accept = w_req_valid && bus.req_ready_i;
  assign w_drop   = bus.rsp_valid_i &&
                    (w_redir || (r_drop_cnt != 2'd0));
  assign w_push   = bus.rsp_valid_i && !w_drop;
  assign w_pop    = w_fifo_valid && bus.inst_ready_i;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc       <= RESET_PC;
      r_out_cnt  <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else begin
      r_out_cnt <= r_out_cnt + {1'b0, w_accept}
                 - {1'b0, bus.rsp_valid_i};
      if (w_redir) begin
        r_pc       <= w_jaddr;
        r_drop_cnt <= r_out_cnt - {1'b0, bus.rsp_valid_i};
      end else begin
        if (w_accept) r_pc <= r_pc + addr_t'(4);
        if (w_drop)   r_drop_cnt <= r_drop_cnt - 2'd1;
      end
    end
  end

  // PCs of in-flight requests; every response retires one, kept or not.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_aq_wp <= 1'b0;
      r_aq_rp <= 1'b0;
      for (int i = 0; i < FETCH_DEPTH; i++) r_aq[i] <= '0;
    end else begin
      if (w_accept) begin
        r_aq[r_aq_wp] <= r_pc;
        r_aq_wp       <= ~r_aq_wp;
      end
      if (bus.rsp_valid_i) r_aq_rp <= ~r_aq_rp;
    end
  end

  fetch_fifo #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_fifo (
    .clk     (sys_clk_i),
    .rst_n   (rst_n_i),
    .i_push  (w_push),
    .i_addr  (r_aq[r_aq_rp]),
    .i_data  (bus.rsp_data_i),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .o_valid (w_fifo_valid),
    .o_addr  (w_fifo_addr),
    .o_data  (w_fifo_data),
    .o_cnt   (w_fifo_cnt)
  );

  assign bus.req_valid_o  = w_req_valid;
  assign bus.req_addr_o   = r_pc;
  assign bus.inst_valid_o = w_fifo_valid;
  assign bus.inst_o       = w_fifo_valid ? w_fifo_data
                                         : DATA_WIDTH'(INST_NOP);
  assign bus.inst_addr_o  = w_fifo_valid ? w_fifo_addr : '0;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: random bus/IF-ID stimulus against a
// PC-stream reference model with a scoreboard queue.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

  inst_fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .bus       (ifc)
  );

  typedef struct {
    logic [31:0] a;
    int          c;
  } breq_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          cyc = 0;
  int          p_rsp = 100;
  bit          stall_chk = 1'b0;
  breq_t       bus_q[$];
  logic [31:0] exp_q[$];

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9E17;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One cycle of stimulus plus the in-order bus model.
  task automatic step(input bit jen, input logic [31:0] ja,
                      input bit rr, input bit ir);
    breq_t b;
    int    out_pre;
    @(negedge clk);
    cyc++;
    ifc.jump_en_i    = jen;
    ifc.jump_addr_i  = ja;
    ifc.req_ready_i  = rr;
    ifc.inst_ready_i = ir;
    ifc.rsp_valid_i  = 1'b0;
    ifc.rsp_data_i   = $urandom;
    out_pre = bus_q.size();
    if (!rst_n) begin
      bus_q.delete();
      out_pre = 0;
    end else if (bus_q.size() > 0 && bus_q[0].c < cyc &&
                 $urandom_range(99) < p_rsp) begin
      b = bus_q.pop_front();
      ifc.rsp_valid_i = 1'b1;
      ifc.rsp_data_i  = mem(b.a);
    end
    #1;
    if (rst_n && ifc.req_valid_o && ifc.req_ready_i) begin
      chk("credit", 32'(out_pre < 2), 32'd1);
      chk("req_align", {30'd0, ifc.req_addr_o[1:0]}, 32'd0);
      b.a = ifc.req_addr_o;
      b.c = cyc;
      bus_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h500, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    int          since;
    bit          halted;
    bit          redir;
    bit          p_hold;
    bit          p_redir;
    bit          p_mis;
    logic [31:0] gen;
    logic [31:0] p_inst;
    logic [31:0] p_addr;
    logic [31:0] e;
    since = 0; halted = 1'b0; gen = RST_PC;
    p_hold = 1'b0; p_redir = 1'b0; p_mis = 1'b0;
    p_inst = '0; p_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_req_valid", 32'(ifc.req_valid_o), 32'd0);
        chk("rst_req_addr", ifc.req_addr_o, RST_PC);
        chk("rst_inst_valid", 32'(ifc.inst_valid_o), 32'd0);
        chk("rst_inst", ifc.inst_o, NOP);
        chk("rst_inst_addr", ifc.inst_addr_o, 32'd0);
        chk("rst_misalign", 32'(ifc.misalign_o), 32'd0);
        since = 0; halted = 1'b0; gen = RST_PC;
        exp_q.delete();
        p_hold = 1'b0; p_redir = 1'b0; p_mis = 1'b0;
        continue;
      end
      if (!halted)
        while (exp_q.size() < 2) begin
          exp_q.push_back(gen);
          gen += 32'd4;
        end
      if (p_hold) begin
        chk("hold_valid", 32'(ifc.inst_valid_o), 32'd1);
        chk("hold_inst", ifc.inst_o, p_inst);
        chk("hold_addr", ifc.inst_addr_o, p_addr);
      end
      if (p_redir) chk("flush", 32'(ifc.inst_valid_o), 32'd0);
`ifdef INST_FETCH_MISALIGN_CHK_EN
      chk("misalign", 32'(ifc.misalign_o), 32'(p_mis));
`else
      chk("misalign", 32'(ifc.misalign_o), 32'd0);
`endif
      if (ifc.inst_valid_o) begin
        if (ifc.inst_ready_i) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pc_unexpected: got %h, want none",
                     ifc.inst_addr_o);
          end else begin
            e = exp_q.pop_front();
            chk("pc", ifc.inst_addr_o, e);
            chk("data", ifc.inst_o, mem(e));
          end
        end
      end else begin
        chk("idle_inst", ifc.inst_o, NOP);
        chk("idle_addr", ifc.inst_addr_o, 32'd0);
      end
      if (since == 0) chk("boot_req", 32'(ifc.req_valid_o), 32'd0);
      if (since == 1) begin
        chk("first_req", 32'(ifc.req_valid_o), 32'd1);
        chk("first_addr", ifc.req_addr_o, RST_PC);
      end
      if (stall_chk) chk("stall_req", 32'(ifc.req_valid_o), 32'd0);
      if (halted && !ifc.jump_en_i)
        chk("halt_req", 32'(ifc.req_valid_o), 32'd0);
      redir = ifc.jump_en_i && (since > 0);
      p_mis = 1'b0;
      if (redir) begin
        exp_q.delete();
`ifdef INST_FETCH_MISALIGN_CHK_EN
        if (ifc.jump_addr_i[1:0] != 2'b00) begin
          halted = 1'b1;
          p_mis  = 1'b1;
        end else begin
          halted = 1'b0;
          gen    = ifc.jump_addr_i;
        end
`else
        gen = ifc.jump_addr_i & ~32'h3;
`endif
      end
      p_hold  = ifc.inst_valid_o && !ifc.inst_ready_i && !redir;
      p_inst  = ifc.inst_o;
      p_addr  = ifc.inst_addr_o;
      p_redir = redir;
      since++;
    end
  end

  initial begin : driver
    logic [31:0] ja;
    bit          jen;
    ifc.req_ready_i  = 1'b0;
    ifc.rsp_valid_i  = 1'b0;
    ifc.rsp_data_i   = '0;
    ifc.jump_en_i    = 1'b0;
    ifc.jump_addr_i  = '0;
    ifc.inst_ready_i = 1'b0;
    do_reset();
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      stall_chk = (i >= 5);
    end
    stall_chk = 1'b0;
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    p_rsp = 0;
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    p_rsp = 100;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h102, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    do_reset();
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) p_rsp = $urandom_range(20, 100);
      jen = ($urandom_range(99) < 5);
      ja  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(99) < 10)
        ja = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(99) < 15)
        ja[1:0] = 2'($urandom_range(1, 3));
      step(jen, ja, $urandom_range(99) < 75, $urandom_range(99) < 70);
    end
    p_rsp = 100;
    step(1'b1, 32'h40, 1'b1, 1'b1);
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("pop_count", 32'(n_pop >= 200), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
